// File: rtl/track_counter.sv
// Closed-loop up/down tracking counter: drives a magnitude comparator with (count, tgt_q)
// and steps count one LSB per cycle toward the latched target until the comparator reports equality.
module track_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_STEPS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic [3:0]       res,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] tgt_q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [4:0]       steps
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [4:0]       steps_q, steps_d;
    logic             budget_hit;
    logic             res_unused;

    assign res_unused = res[3];
    // A further step would make steps reach the budget.
    assign budget_hit = (steps_q == 5'(MAX_STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            steps_q  <= steps_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        steps_d  = steps_q;
        unique case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    target_d = target;
                    steps_d  = '0;
                    state_d  = TRACK;
                end
            end
            TRACK: begin
                unique case (res[2:0])
                    3'b001: begin
                        if ((count_q == '1) || budget_hit) begin
                            state_d = ERR;
                        end else begin
                            count_d = count_q + 1'b1;
                            steps_d = steps_q + 1'b1;
                        end
                    end
                    3'b100: begin
                        if ((count_q == '0) || budget_hit) begin
                            state_d = ERR;
                        end else begin
                            count_d = count_q - 1'b1;
                            steps_d = steps_q + 1'b1;
                        end
                    end
                    3'b010:  state_d = DONE;
                    default: state_d = ERR;
                endcase
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // err needs no separate flag: ERR is left only through an accepted start.
    assign busy  = (state_q == TRACK);
    assign done  = (state_q == DONE);
    assign err   = (state_q == ERR);
    assign count = count_q;
    assign tgt_q = target_q;
    assign steps = steps_q;

endmodule

// File: tb/tb_track_counter.sv
// Self-checking bench for track_counter: behavioural comparator closes the loop,
// expected values come from the distance arithmetic |target - count|.
module tb_track_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] target;
    logic [3:0] res;
    logic [3:0] count;
    logic [3:0] tgt_q;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] steps;

    logic       force_en;
    logic [3:0] force_val;

    int n_checks = 0;
    int n_errors = 0;
    int m_count  = 0;

    track_counter #(.WIDTH(4), .MAX_STEPS(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .target (target),
        .res    (res),
        .count  (count),
        .tgt_q  (tgt_q),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .steps  (steps)
    );

    always #5 clk = ~clk;

    // Behavioural comparator, overridable for fault injection.
    always_comb begin
        if (force_en)            res = force_val;
        else if (count < tgt_q)  res = 4'b0001;
        else if (count == tgt_q) res = 4'b0010;
        else                     res = 4'b0100;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_and_check(input int t);
        int d;
        int e;
        d = (t > m_count) ? t - m_count : m_count - t;
        start  = 1'b1;
        target = 4'(t);
        tick();
        start  = 1'b0;
        target = 4'($urandom);
        n_checks++;
        if (tgt_q !== 4'(t) || busy !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL run_accept: tgt_q=%0d busy=%b err=%b, expected tgt_q=%0d busy=1 err=0", tgt_q, busy, err, t);
        end
        for (int k = 1; k <= d; k++) begin
            tick();
            e = (t > m_count) ? m_count + k : m_count - k;
            n_checks++;
            if (count !== 4'(e) || done !== 1'b0) begin
                n_errors++;
                $display("FAIL run_step%0d: count=%0d done=%b, expected count=%0d done=0", k, count, done, e);
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || steps !== 5'(d) || count !== 4'(t) || err !== 1'b0) begin
            n_errors++;
            $display("FAIL run_done: done=%b busy=%b steps=%0d count=%0d err=%b, expected 1 0 %0d %0d 0", done, busy, steps, count, err, d, t);
        end
        // start during DONE must be ignored
        start  = 1'b1;
        target = 4'(~t);
        tick();
        start  = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || tgt_q !== 4'(t)) begin
            n_errors++;
            $display("FAIL run_after_done: done=%b busy=%b tgt_q=%0d, expected 0 0 %0d", done, busy, tgt_q, t);
        end
        m_count = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (count !== 4'd0 || tgt_q !== 4'd0 || steps !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: count=%0d tgt_q=%0d steps=%0d busy=%b done=%b err=%b, expected all 0", count, tgt_q, steps, busy, done, err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        m_count = 0;
    endtask

    task automatic test_up_run();
        run_and_check(3);
        run_and_check(9);
    endtask

    task automatic test_down_zero();
        run_and_check(12);
        run_and_check(2);
        run_and_check(2);
    endtask

    task automatic test_illegal();
        start  = 1'b1;
        target = 4'd10;
        tick();
        start = 1'b0;
        tick();
        tick();
        force_en  = 1'b1;
        force_val = 4'b0000;
        tick();
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || count !== 4'(m_count + 2) || steps !== 5'd2) begin
            n_errors++;
            $display("FAIL illegal_res: err=%b busy=%b count=%0d steps=%0d, expected 1 0 %0d 2", err, busy, count, steps, m_count + 2);
        end
        tick();
        tick();
        n_checks++;
        if (err !== 1'b1 || count !== 4'(m_count + 2)) begin
            n_errors++;
            $display("FAIL illegal_sticky: err=%b count=%0d, expected 1 %0d", err, count, m_count + 2);
        end
        force_en = 1'b0;
        m_count  = m_count + 2;
        run_and_check(5);
    endtask

    task automatic test_saturation();
        run_and_check(15);
        force_en  = 1'b1;
        force_val = 4'b0001;
        start     = 1'b1;
        target    = 4'($urandom_range(0, 14));
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (err !== 1'b1 || count !== 4'd15 || steps !== 5'd0) begin
            n_errors++;
            $display("FAIL sat_high: err=%b count=%0d steps=%0d, expected 1 15 0", err, count, steps);
        end
        force_en = 1'b0;
        run_and_check(0);
        force_en  = 1'b1;
        force_val = 4'b0100;
        start     = 1'b1;
        target    = 4'($urandom_range(1, 15));
        tick();
        start = 1'b0;
        tick();
        n_checks++;
        if (err !== 1'b1 || count !== 4'd0) begin
            n_errors++;
            $display("FAIL sat_low: err=%b count=%0d, expected 1 0", err, count);
        end
        force_en = 1'b0;
    endtask

    task automatic test_budget();
        int e;
        e = m_count;
        start  = 1'b1;
        target = 4'd8;
        tick();
        start    = 1'b0;
        force_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            force_val = (i % 2 == 0) ? 4'b0001 : 4'b0100;
            tick();
            e = (i % 2 == 0) ? e + 1 : e - 1;
            n_checks++;
            if (count !== 4'(e) || err !== 1'b0) begin
                n_errors++;
                $display("FAIL budget_step%0d: count=%0d err=%b, expected %0d 0", i, count, err, e);
            end
        end
        force_val = 4'b0100;
        tick();
        n_checks++;
        if (err !== 1'b1 || steps !== 5'd15 || count !== 4'(e)) begin
            n_errors++;
            $display("FAIL budget_limit: err=%b steps=%0d count=%0d, expected 1 15 %0d", err, steps, count, e);
        end
        force_en = 1'b0;
        m_count  = e;
        run_and_check(int'($urandom_range(0, 15)));
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            run_and_check(int'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_busy_and_reset();
        run_and_check(4);
        start  = 1'b1;
        target = 4'd9;
        tick();
        start = 1'b0;
        tick();
        start  = 1'b1;
        target = 4'd0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (count !== 4'd9 || tgt_q !== 4'd9 || done !== 1'b1 || steps !== 5'd5) begin
            n_errors++;
            $display("FAIL busy_start: count=%0d tgt_q=%0d done=%b steps=%0d, expected 9 9 1 5", count, tgt_q, done, steps);
        end
        tick();
        m_count = 9;
        run_and_check(0);
        start  = 1'b1;
        target = 4'd9;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        n_checks++;
        if (count !== 4'd6 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset: count=%0d busy=%b, expected 6 1", count, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 4'd0 || tgt_q !== 4'd0 || steps !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: count=%0d tgt_q=%0d steps=%0d busy=%b done=%b err=%b, expected all 0", count, tgt_q, steps, busy, done, err);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd0) begin
                n_errors++;
                $display("FAIL post_reset%0d: done=%b busy=%b count=%0d, expected 0 0 0", k, done, busy, count);
            end
        end
        m_count = 0;
    endtask

    initial begin
        start     = 1'b0;
        target    = 4'd0;
        force_en  = 1'b0;
        force_val = 4'b0000;
        test_reset();
        test_up_run();
        test_down_zero();
        test_illegal();
        test_saturation();
        test_budget();
        test_random();
        test_busy_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/track_counter.md
# track_counter

Closed-loop 4-bit up/down tracking counter that sits on both sides of the magnitude comparator stage. It drives the comparator's A operand with its running count and its B operand with a latched target. It consumes the comparator's one-hot result vector and steps the count toward the target until equality. It reports completion, step count and protocol errors to the controlling logic.

## Interface
- WIDTH, 4, operand width of count and target; comparator result vector is fixed at 4 bits.
- MAX_STEPS, 16, step budget per run; reaching it without equality is an error.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE or ERR.
- target  in  WIDTH  target value, captured on accepted start.
- res  in  4  comparator result for (count, tgt_q): res[0] = lt (count<tgt_q), res[1] = eq, res[2] = gt, res[3] ignored.
- count  out  WIDTH  running count; drives comparator A.
- tgt_q  out  WIDTH  latched target; drives comparator B.
- busy  out  1  high while state is TRACK.
- done  out  1  one-cycle pulse on successful convergence.
- err  out  1  sticky error flag; cleared by the next accepted start.
- steps  out  5  number of +1/-1 steps taken in the current/last run.

## Operation
- States: IDLE, TRACK, DONE, ERR. All outputs are registered or decoded from the state register only.
- Reset values: state=IDLE, count=0, tgt_q=0, steps=0, busy=0, done=0, err=0.
- IDLE: with start=1, capture tgt_q<=target, clear steps to 0 and clear err, then go to TRACK. Count is not reset and each run starts from the previous final count.
- TRACK: the comparator is combinational, so res reflects the current count/tgt_q in the same cycle. Decode res[2:0] each cycle:
  - 3'b001 (lt): count<=count+1, steps<=steps+1.
  - 3'b100 (gt): count<=count-1, steps<=steps+1.
  - 3'b010 (eq): count and steps are held, go to DONE.
  - Any other pattern (none set, or more than one set): go to ERR, count held.
- Saturation guard, no wrap-around: lt with count=all-ones, or gt with count=0, is illegal. The count is held and the state goes to ERR.
- Budget: a step that would make steps equal MAX_STEPS goes to ERR instead, with the count held. With default parameters a correct comparator never reaches the budget, since the maximum distance is 15.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. A start seen in DONE is ignored.
- ERR: err=1 and the state holds until start=1. That start is treated as the IDLE start (recapture target, clear err and steps, go to TRACK).
- start while in TRACK is ignored and the target is not recaptured. The target input is don't-care outside accepted start.
- Reset mid-run returns to IDLE immediately and asynchronously, with count=0 and all outputs at reset values.

## Timing
- Start accepted at edge E0. tgt_q and busy are valid after E0.
- For distance d=|target-count|, count changes at edges E1..Ed, one LSB per edge.
- At edge E(d+1): state goes to DONE and busy falls. done is high from E(d+1) to E(d+2). steps=d.
- d=0: done is high after E1 and steps=0.
- Errors: err rises at the edge that samples the bad res and stays high until the edge after the next accepted start.
- The earliest back-to-back run is a start at E(d+2) (in IDLE).
- There is no combinational path from res to any output.

## Test plan
- Reset: assert rst_n=0 mid-cycle. All outputs go to 0 immediately, with no clock edge, and state is IDLE.
- Up-run: from count=3, start with target=9 and a behavioural comparator. Count goes 4..9 at E1..E6, done pulses after E7, steps=6, err=0.
- Down-run then zero-distance run:
  - From count=12, target=2: 10 decrements, done after E11, steps=10.
  - Then start with target=2: done after E1, steps=0.
- Illegal result: force res=4'b0000 in TRACK. err=1 next edge, count frozen, busy=0. Then start with target=5 clears err and converges normally.
- Saturation: with count=15, force res=4'b0001 (lt). Count stays 15 and err=1. Mirror case: count=0 with gt gives count=0 and err=1.
- Busy/start and reset mid-run:
  - Assert start with target=0 during a run toward 9. The run still ends at 9.
  - Pull rst_n low at count=6. count=0 and state is IDLE, with no done pulse.
